// File: rtl/add_sub_multicycle.sv
// ---------------------------------------------------------------------------
// add_sub_multicycle
//
// Multi-cycle two's-complement adder/subtractor. An operation is accepted on
// start while idle, then CHUNK bits are added per cycle, LSB first, for
// N = WIDTH/CHUNK cycles. The result and flags are registered and are loaded
// on the same edge that raises the one-cycle done pulse. WIDTH must be a
// multiple of CHUNK. CHUNK = WIDTH gives single-cycle operation.
//
// Ports
//   clk       in   1      clock, rising edge
//   reset_n   in   1      synchronous active-low reset
//   start     in   1      request, sampled only while busy = 0
//   a, b      in   WIDTH  operands, sampled with start
//   c_in      in   1      carry-in (add) / borrow-in (sub), sampled with start
//   sub       in   1      1: a - b - c_in, 0: a + b + c_in, sampled with start
//   busy      out  1      operation in progress
//   done      out  1      one-cycle pulse, results valid
//   sum       out  WIDTH  result, held until the next completion
//   c_out     out  1      carry out of the MSB (sub: 1 = no borrow)
//   overflow  out  1      signed overflow
//   zero      out  1      sum == 0
// ---------------------------------------------------------------------------
module add_sub_multicycle #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK:0]   slice;
    logic [WIDTH-1:0] res_next;
    logic             msb_cin;
    logic             last;

    // One CHUNK-bit slice of the ripple add. The slice result enters the top
    // of the result register so that after N slices it is fully aligned.
    // Shifts are used instead of part-selects so CHUNK = WIDTH elaborates
    // without a reversed range.
    // NOTE: every signal written here gets its value on every path, so no
    // latch is inferred.
    always_comb begin
        slice    = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, carry};
        res_next = (res >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
        // Carry into the slice MSB, recovered from its sum bit; on the final
        // slice this is the carry into bit WIDTH-1.
        msb_cin  = a_r[CHUNK-1] ^ b_r[CHUNK-1] ^ slice[CHUNK-1];
        last     = (cnt == CW'(N - 1));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: operand and result registers are cleared too; this is a
            // handful of flops, not a memory, and a clean restart is wanted.
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        // Subtract as A + ~B + 1; a borrow-in removes the +1.
                        b_r   <= sub ? ~b : b;
                        carry <= c_in ^ sub;
                        res   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> CHUNK;
                    b_r   <= b_r >> CHUNK;
                    carry <= slice[CHUNK];
                    res   <= res_next;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= res_next;
                        c_out    <= slice[CHUNK];
                        overflow <= msb_cin ^ slice[CHUNK];
                        zero     <= (res_next == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_multicycle.sv
// ---------------------------------------------------------------------------
// tb_add_sub_multicycle
//
// Directed bench for add_sub_multicycle. An 8/4 instance covers the directed
// arithmetic cases, busy/back-to-back and reset mid-operation. Three 32-bit
// instances (CHUNK = 1, 4, 32) share stimulus and are compared against a
// behavioural a +/- b +/- c_in model, including latency and pulse width.
// ---------------------------------------------------------------------------
module tb_add_sub_multicycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // 8-bit, CHUNK = 4 instance
    logic       start8, c_in8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, c_out8, ov8, zero8;
    logic [7:0] sum8;

    add_sub_multicycle #(.WIDTH(8), .CHUNK(4)) u8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
        .c_in(c_in8), .sub(sub8), .busy(busy8), .done(done8), .sum(sum8),
        .c_out(c_out8), .overflow(ov8), .zero(zero8)
    );

    // 32-bit instances, CHUNK = 1, 4, 32, driven in lockstep
    logic        start32, c_in32, sub32;
    logic [31:0] a32, b32;
    logic        busy_w[3], done_w[3], c_out_w[3], ov_w[3], zero_w[3];
    logic [31:0] sum_w[3];

    add_sub_multicycle #(.WIDTH(32), .CHUNK(1)) u32_c1 (
        .clk(clk), .reset_n(reset_n), .start(start32), .a(a32), .b(b32),
        .c_in(c_in32), .sub(sub32), .busy(busy_w[0]), .done(done_w[0]),
        .sum(sum_w[0]), .c_out(c_out_w[0]), .overflow(ov_w[0]), .zero(zero_w[0])
    );
    add_sub_multicycle #(.WIDTH(32), .CHUNK(4)) u32_c4 (
        .clk(clk), .reset_n(reset_n), .start(start32), .a(a32), .b(b32),
        .c_in(c_in32), .sub(sub32), .busy(busy_w[1]), .done(done_w[1]),
        .sum(sum_w[1]), .c_out(c_out_w[1]), .overflow(ov_w[1]), .zero(zero_w[1])
    );
    add_sub_multicycle #(.WIDTH(32), .CHUNK(32)) u32_c32 (
        .clk(clk), .reset_n(reset_n), .start(start32), .a(a32), .b(b32),
        .c_in(c_in32), .sub(sub32), .busy(busy_w[2]), .done(done_w[2]),
        .sum(sum_w[2]), .c_out(c_out_w[2]), .overflow(ov_w[2]), .zero(zero_w[2])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge; inputs driven here are
    // sampled at the following edge, outputs read here are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 8-bit operation: accept, two RUN edges, done, then pulse ends.
    task automatic op8(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                       input logic ci, input logic si, input logic [7:0] es,
                       input logic ec, input logic eo);
        a8 = ai; b8 = bi; c_in8 = ci; sub8 = si; start8 = 1'b1;
        tick();                               // T: accept
        start8 = 1'b0;
        check({tag, " busy@T"}, busy8, 1'b1);
        tick();                               // T+1
        check({tag, " done@T+1"}, done8, 1'b0);
        tick();                               // T+2
        check({tag, " done@T+2"}, done8, 1'b1);
        check({tag, " busy@T+2"}, busy8, 1'b0);
        check({tag, " sum"}, sum8, es);
        check({tag, " c_out"}, c_out8, ec);
        check({tag, " overflow"}, ov8, eo);
        check({tag, " zero"}, zero8, (es == 8'h00));
        tick();
        check({tag, " done pulse end"}, done8, 1'b0);
    endtask

    // Behavioural reference: unsigned 33-bit and signed 64-bit arithmetic.
    task automatic model32(input logic [31:0] ai, input logic [31:0] bi,
                           input logic ci, input logic si,
                           output logic [31:0] es, output logic ec, output logic eo);
        logic [32:0] u;
        longint      r;
        if (si) begin
            u  = {1'b0, ai} - {1'b0, bi} - {32'd0, ci};
            r  = longint'($signed(ai)) - longint'($signed(bi)) - longint'(ci);
            ec = ~u[32];
        end else begin
            u  = {1'b0, ai} + {1'b0, bi} + {32'd0, ci};
            r  = longint'($signed(ai)) + longint'($signed(bi)) + longint'(ci);
            ec = u[32];
        end
        es = u[31:0];
        eo = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endtask

    int          exp_lat[3] = '{32, 8, 1};
    int          lat[3];
    int          pulses[3];
    logic [31:0] es32;
    logic        ec32, eo32;

    initial begin
        reset_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; c_in8 = 1'b0; sub8 = 1'b0;
        start32 = 1'b0; a32 = '0; b32 = '0; c_in32 = 1'b0; sub32 = 1'b0;
        tick();
        tick();
        check("reset busy", busy8, 1'b0);
        check("reset done", done8, 1'b0);
        check("reset sum", sum8, 8'h00);
        check("reset c_out/ov/zero", {c_out8, ov8, zero8}, 3'b000);
        check("reset busy32", {busy_w[0], busy_w[1], busy_w[2]}, 3'b000);
        reset_n = 1'b1;
        tick();

        // Directed arithmetic, WIDTH = 8, CHUNK = 4
        op8("sub 02-01",    8'h02, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
        op8("add 7F+01",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("add FF+01",    8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("sub 07-06-1",  8'h07, 8'h06, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
        op8("sub 00-01",    8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        op8("sub 80-01",    8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        op8("add 0F+01+1",  8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);

        // Busy: a start one cycle after acceptance is ignored
        a8 = 8'h10; b8 = 8'h20; c_in8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        tick();                               // T: accept 10+20
        a8 = 8'h55; b8 = 8'h11; sub8 = 1'b1;  // start still high at T+1
        tick();                               // T+1: ignored
        start8 = 1'b0;
        check("busy ignore still busy", busy8, 1'b1);
        tick();                               // T+2
        check("busy ignore done", done8, 1'b1);
        check("busy ignore sum", sum8, 8'h30);
        // Back-to-back: start during the done cycle
        a8 = 8'h03; b8 = 8'h04; c_in8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        tick();                               // T+3: accept 03+04
        start8 = 1'b0;
        check("b2b busy", busy8, 1'b1);
        check("b2b done low", done8, 1'b0);
        tick();                               // T+4
        check("b2b sum held in RUN", sum8, 8'h30);
        check("b2b done@+1", done8, 1'b0);
        tick();                               // T+5
        check("b2b done@+2", done8, 1'b1);
        check("b2b sum", sum8, 8'h07);
        tick();

        // Reset one cycle after accept
        a8 = 8'hF0; b8 = 8'h0F; c_in8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        tick();                               // accept
        start8 = 1'b0;
        reset_n = 1'b0;
        tick();                               // reset edge
        reset_n = 1'b1;
        check("midrst busy", busy8, 1'b0);
        check("midrst done", done8, 1'b0);
        check("midrst sum", sum8, 8'h00);
        check("midrst flags", {c_out8, ov8, zero8}, 3'b000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("midrst no done", done8, 1'b0);
        end
        op8("after reset", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

        // Parameter sweep, WIDTH = 32, CHUNK = 1 / 4 / 32
        for (int v = 0; v < 1000; v++) begin
            a32    = $urandom;
            b32    = $urandom;
            sub32  = 1'($urandom_range(0, 1));
            c_in32 = 1'($urandom_range(0, 1));
            if (v == 0) begin a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; sub32 = 1'b0; c_in32 = 1'b0; end
            if (v == 1) begin a32 = 32'h0000_0000; b32 = 32'hFFFF_FFFF; sub32 = 1'b1; c_in32 = 1'b1; end
            if (v == 2) begin a32 = 32'h1234_5678; b32 = 32'h1234_5678; sub32 = 1'b1; c_in32 = 1'b0; end
            model32(a32, b32, c_in32, sub32, es32, ec32, eo32);
            start32 = 1'b1;
            tick();                           // accept
            start32 = 1'b0;
            for (int i = 0; i < 3; i++) begin
                lat[i]    = 0;
                pulses[i] = 0;
            end
            for (int k = 1; k <= 33; k++) begin
                tick();
                for (int i = 0; i < 3; i++) begin
                    if (done_w[i]) begin
                        pulses[i]++;
                        if (lat[i] == 0) lat[i] = k;
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                check($sformatf("sweep%0d v%0d latency", i, v), lat[i], exp_lat[i]);
                check($sformatf("sweep%0d v%0d pulses", i, v), pulses[i], 1);
                check($sformatf("sweep%0d v%0d sum", i, v), sum_w[i], es32);
                check($sformatf("sweep%0d v%0d c_out", i, v), c_out_w[i], ec32);
                check($sformatf("sweep%0d v%0d overflow", i, v), ov_w[i], eo32);
                check($sformatf("sweep%0d v%0d zero", i, v), zero_w[i], (es32 == 32'd0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
